// File: rtl/aes_round_sequencer.sv
// AES round sequencer: owns the block state register and round counter, fetches
// one round key per round over req/ack and hands the finished block downstream.
module aes_round_sequencer #(
    parameter int unsigned SENTENCE = 128,
    parameter int unsigned ROUNDS   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SENTENCE-1:0] data_in,
    output logic [3:0]          Round_Number,
    output logic [SENTENCE-1:0] state_out,
    input  logic [SENTENCE-1:0] round_result,
    output logic                key_req,
    input  logic                key_ack,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SENTENCE-1:0] data_out,
    output logic                busy
);

    localparam int unsigned RN_W = 4;
    localparam logic [RN_W-1:0] LAST_ROUND = RN_W'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [SENTENCE-1:0] state_q, state_d;
    logic [RN_W-1:0]     round_q, round_d;

    // State, datapath and round counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = data_in;
                    round_d = '0;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (key_ack) begin
                    state_d = round_result;
                    if (round_q == LAST_ROUND) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q + RN_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    round_d = '0;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                fsm_d   = IDLE;
                round_d = '0;
            end
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        in_ready  = 1'b0;
        key_req   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ROUND:   key_req   = 1'b1;
            DONE:    out_valid = 1'b1;
            default: busy      = 1'b1;
        endcase
    end

    assign Round_Number = round_q;
    assign state_out    = state_q;
    assign data_out     = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: the round datapath is modelled as
// state+1, so each finished block must equal plaintext + ROUNDS + 1.
module tb_aes_round_sequencer;

    localparam int unsigned W = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] data_in;
    logic [3:0]   Round_Number;
    logic [W-1:0] state_out, round_result, data_out;
    logic         key_req, out_valid, busy;
    logic         key_ack   = 1'b0;
    logic         out_ready = 1'b0;

    logic         iv14, ir14, kr14, ov14, busy14;
    logic [W-1:0] din14, so14, rr14, do14;
    logic [3:0]   rn14;

    int checks = 0, failures = 0;
    int cyc = 0;
    logic [W-1:0] sb_q[$];

    // Stimulus-controlled knobs read by the driver process
    logic or_val, rand_mode;
    int   stall, exp_lat;
    int   cnt = 0;

    // Monitor-side model state
    int           rn_exp = 0, acc_cyc = 0, max_rn14 = 0;
    logic [W-1:0] cur_blk = '0, prev_data = '0;
    logic         prev_valid = 1'b0, prev_ready = 1'b0;

    assign round_result = state_out + W'(1);
    assign rr14         = so14 + W'(1);

    aes_round_sequencer #(.SENTENCE(128), .ROUNDS(10)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .Round_Number(Round_Number), .state_out(state_out),
        .round_result(round_result), .key_req(key_req), .key_ack(key_ack),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .busy(busy)
    );

    aes_round_sequencer #(.SENTENCE(128), .ROUNDS(14)) u_dut14 (
        .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(ir14),
        .data_in(din14), .Round_Number(rn14), .state_out(so14),
        .round_result(rr14), .key_req(kr14), .key_ack(1'b1),
        .out_valid(ov14), .out_ready(1'b1), .data_out(do14),
        .busy(busy14)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Key-schedule and consumer emulation
    always @(posedge clk) begin
        #2;
        if (rand_mode) begin
            key_ack   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
        end else begin
            out_ready = or_val;
            if (!key_req || cnt == stall) begin
                key_ack = 1'b1;
                cnt     = 0;
            end else begin
                key_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Monitor: round sequence, hold behaviour, latency and scoreboard pops
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                rn_exp  = 0;
                cur_blk = data_in;
                acc_cyc = cyc + 1;
            end
            if (key_req) begin
                chk("ready_low_in_round", W'(in_ready), W'(0));
                chk("round_number", W'(Round_Number), W'(rn_exp));
                chk("state_in_round", state_out, cur_blk + W'(rn_exp));
                if (key_ack) rn_exp++;
            end
            chk("round_in_range", W'(Round_Number <= 4'd10), W'(1));
            if (out_valid && !prev_valid && exp_lat >= 0)
                chk("latency", W'(cyc - acc_cyc), W'(exp_lat));
            if (out_valid && prev_valid && !prev_ready)
                chk("data_out_stable", data_out, prev_data);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", W'(1), W'(0));
                end else begin
                    chk("ciphertext", data_out, sb_q.pop_front());
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = data_out;
        end else begin
            prev_valid = 1'b0;
        end
        if (int'(rn14) > max_rn14) max_rn14 = int'(rn14);
    end

    task automatic send(input logic [W-1:0] blk, input int lat);
        logic acc;
        int   n;
        acc      = 1'b0;
        n        = 0;
        exp_lat  = lat;
        in_valid = 1'b1;
        data_in  = blk;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", W'(0), W'(1));
        else sb_q.push_back(blk + W'(11));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", W'(sb_q.size()), W'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] a, b, x, d14;
        int n;
        rst = 1'b1; in_valid = 1'b0; data_in = '0; iv14 = 1'b0; din14 = '0;
        or_val = 1'b1; rand_mode = 1'b0; stall = 0; exp_lat = -1;

        #12;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_key_req", W'(key_req), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_round", W'(Round_Number), W'(0));
        chk("rst_state", state_out, W'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Plain run, then with three stall cycles before every ack
        send(W'(5), 11);
        drain();
        stall = 3;
        send(W'(5), 44);
        drain();
        stall = 0;

        // Output backpressure with a competing block waiting
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        or_val = 1'b0;
        send(a, 11);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_reach_done", W'(out_valid), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b1; data_in = b;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", W'(out_valid), W'(1));
            chk("bp_data_held", data_out, a + W'(11));
            chk("bp_in_ready_low", W'(in_ready), W'(0));
        end
        @(posedge clk); #1 or_val = 1'b1;
        @(posedge clk); #3;
        chk("bp_idle_valid", W'(out_valid), W'(0));
        chk("bp_idle_ready", W'(in_ready), W'(1));
        chk("bp_idle_round", W'(Round_Number), W'(0));
        @(posedge clk); #3;
        chk("bp_accept_req", W'(key_req), W'(1));
        chk("bp_accept_state", state_out, b);
        in_valid = 1'b0;
        sb_q.push_back(b + W'(11));
        drain();

        // Back-to-back blocks
        send(W'(1), 11);
        send(W'(256), 11);
        drain();

        // Asynchronous reset in the middle of a block
        x = {$urandom, $urandom, $urandom, $urandom};
        send(x, 11);
        n = 0;
        do begin @(negedge clk); n++; end while (Round_Number != 4'd6 && n < 100);
        chk("reach_round6", W'(Round_Number), W'(6));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_round", W'(Round_Number), W'(0));
        chk("mid_rst_state", state_out, W'(0));
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        chk("mid_rst_key_req", W'(key_req), W'(0));
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_busy", W'(busy), W'(0));
        void'(sb_q.pop_back());
        @(posedge clk); #1 rst = 1'b0;
        send(W'(7), 11);
        drain();

        // ROUNDS=14 instance
        d14 = {$urandom, $urandom, $urandom, $urandom};
        max_rn14 = 0;
        iv14 = 1'b1; din14 = d14;
        @(posedge clk); #1 iv14 = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ov14 && n < 100);
        chk("r14_latency", W'(n), W'(15));
        chk("r14_data", do14, d14 + W'(15));
        chk("r14_max_round", W'(max_rn14), W'(14));

        // Randomized blocks with random key stalls and output backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            send({$urandom, $urandom, $urandom, $urandom}, -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", W'(sb_q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Sequences one AES block through the encryption round datapath: the round mux, SubBytes/ShiftRows/MixColumns and AddRoundKey stages.
- Owns the 128-bit state register and the Round_Number counter that drives the round mux select.
- Requests each round key from the key schedule over a req/ack handshake.
- Accepts one block at a time on a valid/ready input and returns the ciphertext on a valid/ready output.

Parameters:
SENTENCE, 128, block/state width in bits
ROUNDS, 10, index of the final round; legal values 10, 12, 14 (AES-128/192/256)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  data_in holds a block to encrypt
in_ready  output  1  sequencer can accept a block
data_in  input  SENTENCE  plaintext block
Round_Number  output  4  current round index, drives round mux select and key schedule index
state_out  output  SENTENCE  current state register value, fed to the round datapath
round_result  input  SENTENCE  combinational output of the round datapath for (state_out, Round_Number, round key)
key_req  output  1  round key for Round_Number requested
key_ack  input  1  round key valid this cycle; round_result valid
out_valid  output  1  data_out holds the finished ciphertext
out_ready  input  1  consumer accepts data_out
data_out  output  SENTENCE  ciphertext, equals state register
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): FSM=IDLE, Round_Number=0, state register=0, in_ready=1, key_req=0, out_valid=0, busy=0. Release takes effect at the next clk edge.
- FSM states: IDLE, ROUND, DONE. All outputs are registered or decoded from FSM state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at a clk edge: state<=data_in, Round_Number<=0, go to ROUND.
- ROUND:
  - key_req=1, in_ready=0; in_valid is ignored.
  - Without key_ack: hold state, Round_Number and FSM; key_req stays high.
  - With key_ack: state<=round_result.
    - If Round_Number==ROUNDS: go to DONE; Round_Number holds ROUNDS.
    - Otherwise Round_Number<=Round_Number+1.
- DONE:
  - out_valid=1, data_out=state; data_out is stable while out_valid & !out_ready.
  - On out_ready: go to IDLE, Round_Number<=0.
  - No same-cycle restart: the next in_valid is accepted the cycle after the DONE->IDLE edge.
- key_ack is ignored outside ROUND. out_ready is ignored outside DONE.
- Latency with key_ack tied high: acceptance edge E0, key acks at edges E1..E(ROUNDS+1), out_valid high after edge E(ROUNDS+1). That is 11 cycles for ROUNDS=10.
- Round_Number never exceeds ROUNDS. It takes no values outside 0..ROUNDS, so the round mux default branch is never selected.
- rst asserted mid-round: immediate return to the reset values; the partial block is discarded and no out_valid pulse is produced.
- state_out always equals the internal state register.

Test Plan:
- Bench round model is round_result = state_out + 1 (mod 2^128), with key_ack tied high. Accept data_in=0x0000...0005: out_valid rises exactly 11 cycles after acceptance, data_out=0x0000...0010, Round_Number sequence 0,1,...,10.
- key_ack stalls: same model, key_ack low for 3 cycles before every ack. out_valid rises after 11 + 33 = 44 cycles, data_out unchanged vs. the previous test. Round_Number and state hold during stalls, key_req stays 1.
- Output backpressure: out_ready held low 5 cycles in DONE. data_out and out_valid stay stable, in_ready=0, a second in_valid is not accepted. It is accepted 1 cycle after out_ready.
- Back-to-back blocks 0x1 then 0x100 with out_ready=1: outputs are 0xC then 0x10B in order, and in_ready is low for the whole of each block.
- Async reset asserted when Round_Number=6, between clock edges. Outputs go to reset values immediately, no out_valid. The next block 0x7 then yields 0x12.
- ROUNDS=14 instance: Round_Number reaches 14, out_valid after 15 cycles, data_out = data_in + 15.
